// File: rtl/dm_responder_if.sv
// dm_responder_if
// Bundles the CPU M-stage data port and the store-trace drain port of
// dm_responder into one interface.
//   master : CPU / trace consumer side. Drives the address, write data,
//            byte enables, instruction address and trace_ready. Receives
//            read data, status flags and the trace FIFO head.
//   slave  : responder side. Signal directions are the reverse of master.
// Parameter TRACE_DEPTH must match the responder's TRACE_DEPTH. It sets the
// width of trace_count.
interface dm_responder_if #(
  parameter int TRACE_DEPTH = 8
);
  localparam int TW = $clog2(TRACE_DEPTH);

  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        init_busy;
  logic        addr_err;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [3:0]  trace_byteen;
  logic [TW:0] trace_count;
  logic        trace_overflow;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    input  m_data_rdata, init_busy, addr_err, trace_valid, trace_pc,
           trace_addr, trace_data, trace_byteen, trace_count, trace_overflow
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    output m_data_rdata, init_busy, addr_err, trace_valid, trace_pc,
           trace_addr, trace_data, trace_byteen, trace_count, trace_overflow
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder
// Data-memory responder for the CPU M stage.
// - Reads are combinational and return a whole 32-bit word.
// - Writes are byte-lane writes, applied at the clock edge.
// - Every accepted store is also logged to a trace FIFO. The consumer
//   drains that FIFO through a valid/ready handshake.
// - After reset the RAM is swept to zero, one word per cycle. The port
//   is inert until the sweep completes.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : dm_responder_if.slave, carrying these signals:
//           - CPU side: m_data_addr, m_data_wdata, m_data_byteen,
//             m_inst_addr, m_data_rdata
//           - status: init_busy, addr_err
//           - trace drain: trace_valid, trace_ready, trace_pc, trace_addr,
//             trace_data, trace_byteen, trace_count, trace_overflow
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int TRACE_DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  dm_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int TW = $clog2(TRACE_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } trace_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] init_cnt;
  logic [31:0]   ram [DEPTH_WORDS];

  logic [AW-1:0] index;
  logic          in_range;
  logic [31:0]   word_addr;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic          running;
  logic          store_req;
  logic          accept;
  logic          out_of_range;

  trace_t        fifo_mem [TRACE_DEPTH];
  trace_t        head;
  logic [TW-1:0] wr_ptr;
  logic [TW-1:0] rd_ptr;
  logic [TW:0]   count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          addr_err_q;
  logic          overflow_q;

  assign running   = (state == ST_RUN);
  assign index     = bus.m_data_addr[AW+1:2];
  assign in_range  = (bus.m_data_addr[31:AW+2] == '0);
  // The byte offset within the word never selects storage; it is masked
  // off for the word address that goes into the trace record.
  assign word_addr = bus.m_data_addr & 32'hFFFF_FFFC;
  assign old_word  = ram[index];

  assign store_req    = running && (bus.m_data_byteen != 4'b0000);
  assign accept       = store_req && in_range;
  assign out_of_range = store_req && !in_range;

  // State register for the sweep/run controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_next;
  end

  // Leave INIT on the same edge that clears the last word.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_cnt == AW'(DEPTH_WORDS - 1)) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Sweep address, restarted from word 0 by every reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
  end

  // Merge the enabled store lanes over the current word. The same value
  // feeds both the RAM write and the trace record.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (bus.m_data_byteen[i]) merged[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
    end
  end

  // RAM has no reset of its own. The INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) ram[init_cnt] <= '0;
    else if (accept)      ram[index]    <= merged;
  end

  assign bus.m_data_rdata = (running && in_range) ? old_word : 32'h0;
  assign bus.init_busy    = (state == ST_INIT);

  // Trace FIFO control.
  // A pop frees a slot in the same cycle, so a store that arrives while
  // the FIFO is full is kept whenever the consumer is popping.
  assign empty = (count == '0);
  assign full  = (count == (TW+1)'(TRACE_DEPTH));
  assign pop   = !empty && bus.trace_ready;
  assign push  = accept && (!full || pop);
  assign drop  = accept && full && !pop;

  // Trace storage. Its contents are only visible through the head,
  // which is masked to zero when the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{bus.m_inst_addr, word_addr, merged, bus.m_data_byteen};
  end

  // Pointers wrap naturally at TW bits. The extra count bit distinguishes
  // full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags. Only a reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (out_of_range) addr_err_q <= 1'b1;
      if (drop)         overflow_q <= 1'b1;
    end
  end

  assign head               = empty ? '0 : fifo_mem[rd_ptr];
  assign bus.trace_valid    = !empty;
  assign bus.trace_pc       = head.pc;
  assign bus.trace_addr     = head.addr;
  assign bus.trace_data     = head.data;
  assign bus.trace_byteen   = head.byteen;
  assign bus.trace_count    = count;
  assign bus.trace_overflow = overflow_q;
  assign bus.addr_err       = addr_err_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder
// Self-checking bench for dm_responder.
// The reference model keeps the following:
//   - a plain word array for the RAM
//   - a queue for the FIFO contents, capped at TRACE_DEPTH
//   - sticky-flag bits
// Each stimulus cycle pushes the expected popped record into a scoreboard
// queue. A separate monitor compares that record with the head whenever
// the DUT shows a valid/ready transfer.
`timescale 1ns/1ps
module tb_dm_responder;
  localparam int DEPTH_WORDS = 1024;
  localparam int TRACE_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  dm_responder_if #(.TRACE_DEPTH(TRACE_DEPTH)) bus();

  dm_responder #(.DEPTH_WORDS(DEPTH_WORDS), .TRACE_DEPTH(TRACE_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_model [DEPTH_WORDS];
  rec_t        exp_q[$];
  rec_t        sb_q[$];
  bit          model_run;
  bit          model_err;
  bit          model_ovf;
  int          checks = 0;
  int          failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic driveIdle();
    bus.m_data_addr   = 32'h0;
    bus.m_data_wdata  = 32'h0;
    bus.m_data_byteen = 4'h0;
    bus.m_inst_addr   = 32'h0;
    bus.trace_ready   = 1'b0;
  endtask

  // One CPU cycle. The call does the following, in order:
  //   1. Drives the inputs at the falling edge.
  //   2. Checks the pre-edge state one time unit before the rising edge.
  //   3. Advances the model by what that edge should do.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] pc, input logic rdy);
    int          idx;
    bit          inr;
    bit          pop;
    logic [31:0] exp_rd;
    logic [31:0] merged;
    rec_t        r;
    @(negedge clk);
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = wdata;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    bus.trace_ready   = rdy;
    inr = (addr < 32'(DEPTH_WORDS * 4));
    idx = inr ? int'(addr / 4) : 0;
    pop = rdy && (exp_q.size() > 0);
    if (pop) sb_q.push_back(exp_q[0]);
    #4;
    exp_rd = (model_run && inr) ? mem_model[idx] : 32'h0;
    checkOutput("rdata", bus.m_data_rdata, exp_rd);
    checkOutput("init_busy", 32'(bus.init_busy), 32'(!model_run));
    checkOutput("addr_err", 32'(bus.addr_err), 32'(model_err));
    checkOutput("trace_overflow", 32'(bus.trace_overflow), 32'(model_ovf));
    checkOutput("trace_count", 32'(bus.trace_count), 32'(exp_q.size()));
    checkOutput("trace_valid", 32'(bus.trace_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      checkOutput("head_pc", bus.trace_pc, exp_q[0].pc);
      checkOutput("head_addr", bus.trace_addr, exp_q[0].addr);
      checkOutput("head_data", bus.trace_data, exp_q[0].data);
      checkOutput("head_byteen", 32'(bus.trace_byteen), 32'(exp_q[0].byteen));
    end else begin
      checkOutput("empty_head", bus.trace_pc | bus.trace_addr | bus.trace_data | 32'(bus.trace_byteen), 32'h0);
    end
    if (pop) void'(exp_q.pop_front());
    if (model_run && be != 4'h0) begin
      if (inr) begin
        merged = mem_model[idx];
        for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        mem_model[idx] = merged;
        r = '{pc, addr & 32'hFFFF_FFFC, merged, be};
        if (exp_q.size() < TRACE_DEPTH) exp_q.push_back(r);
        else model_ovf = 1'b1;
      end else begin
        model_err = 1'b1;
      end
    end
  endtask

  // Assert reset now (caller is at a falling edge) and check the
  // asynchronous reset values. Then hold for 'cycles' cycles and release.
  task automatic doReset(input int cycles);
    reset = 1'b1;
    driveIdle();
    exp_q.delete();
    sb_q.delete();
    model_run = 1'b0;
    model_err = 1'b0;
    model_ovf = 1'b0;
    #1;
    checkOutput("rst_init_busy", 32'(bus.init_busy), 32'h1);
    checkOutput("rst_flags", {30'h0, bus.addr_err, bus.trace_overflow}, 32'h0);
    checkOutput("rst_count", 32'(bus.trace_count), 32'h0);
    checkOutput("rst_valid", 32'(bus.trace_valid), 32'h0);
    checkOutput("rst_rdata", bus.m_data_rdata, 32'h0);
    checkOutput("rst_head", bus.trace_pc | bus.trace_addr | bus.trace_data | 32'(bus.trace_byteen), 32'h0);
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called right after reset release at a falling edge. Counts the cycles
  // for which init_busy is high, bounded so a stuck sweep cannot hang the run.
  task automatic waitInit();
    int n = 0;
    while (n < 2000) begin
      #4;
      if (bus.init_busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    checkOutput("init_cycles", 32'(n), 32'(DEPTH_WORDS));
    foreach (mem_model[i]) mem_model[i] = 32'h0;
    model_run = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 4 * TRACE_DEPTH) begin
      applyStimulus(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
      guard++;
    end
    applyStimulus(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  // Scoreboard monitor: every transfer the DUT performs must match the
  // oldest expected record.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #4;
      if (reset === 1'b0 && bus.trace_valid === 1'b1 && bus.trace_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pop actual=pc 0x%08h required=no transfer", bus.trace_pc);
        end else begin
          r = sb_q.pop_front();
          checkOutput("pop_pc", bus.trace_pc, r.pc);
          checkOutput("pop_addr", bus.trace_addr, r.addr);
          checkOutput("pop_data", bus.trace_data, r.data);
          checkOutput("pop_byteen", 32'(bus.trace_byteen), 32'(r.byteen));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    driveIdle();
    @(negedge clk);
    doReset(3);
    waitInit();

    $display("[TB] basic read after sweep");
    applyStimulus(32'h0000_0010, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("[TB] full and partial writes");
    applyStimulus(32'h40, 32'hDEAD_BEEF, 4'hF, 32'h3010, 1'b0);
    applyStimulus(32'h40, 32'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(32'h43, 32'h1100_0000, 4'h8, 32'h3014, 1'b0);
    applyStimulus(32'h40, 32'h0000_2222, 4'h3, 32'h3018, 1'b0);
    applyStimulus(32'h40, 32'h0, 4'h0, 32'h0, 1'b0);
    drain();

    $display("[TB] FIFO fill and overflow");
    for (int k = 0; k < 9; k++)
      applyStimulus(32'h100 + 32'(4 * k), $urandom, 4'hF, 32'h3000 + 32'(4 * k), 1'b0);
    applyStimulus(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    drain();

    $display("[TB] out-of-range stores");
    applyStimulus(32'h0000_1000, 32'h1234_5678, 4'hF, 32'h3100, 1'b0);
    applyStimulus(32'h8000_0040, 32'h1234_5678, 4'hF, 32'h3104, 1'b0);
    applyStimulus(32'h40, 32'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(32'h0000_1000, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("[TB] reset in the middle of the sweep");
    @(negedge clk);
    doReset(3);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #1;
      checkOutput("busy_during_init", 32'(bus.init_busy), 32'h1);
    end
    @(negedge clk);
    doReset(2);
    waitInit();

    $display("[TB] push and pop on a full FIFO");
    for (int k = 0; k < TRACE_DEPTH; k++)
      applyStimulus(32'h200 + 32'(4 * k), $urandom, 4'hF, 32'h4000 + 32'(4 * k), 1'b0);
    applyStimulus(32'h300, 32'hCAFE_F00D, 4'h5, 32'h4100, 1'b1);
    applyStimulus(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    drain();

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      a = ($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a | 32'h0000_0FC0;
      if ($urandom_range(0, 7) == 0)  a = a | (32'h1 << $urandom_range(12, 31));
      applyStimulus(a, $urandom, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
    end
    drain();
    applyStimulus(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
Data-memory responder for the pipelined CPU's M-stage data port. It takes the CPU's m_data_addr, m_data_wdata, m_data_byteen and m_inst_addr, returns m_data_rdata combinationally, and applies byte-lane writes. Every accepted store is also recorded in a trace FIFO, which the bench drains through a valid/ready handshake. After reset the block zero-fills its RAM with a sweep and reports completion on init_busy.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words; power of 2; AW = log2(DEPTH_WORDS)
TRACE_DEPTH, 8, store-trace FIFO entries; power of 2; TW = log2(TRACE_DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
m_data_addr  in  32  byte address from CPU M stage
m_data_wdata  in  32  store data, already shifted into byte lanes
m_data_byteen  in  4  byte-lane write enables; 0 means no write
m_inst_addr  in  32  PC of the M-stage instruction
m_data_rdata  out  32  word read data, combinational
init_busy  out  1  zero-fill sweep in progress
addr_err  out  1  sticky flag: out-of-range store seen
trace_valid  out  1  FIFO head is valid
trace_ready  in  1  consumer accepts head
trace_pc  out  32  head: store PC
trace_addr  out  32  head: word-aligned address (bits [1:0] = 0)
trace_data  out  32  head: full word contents after the store
trace_byteen  out  4  head: byte enables of the store
trace_count  out  TW+1  FIFO occupancy
trace_overflow  out  1  sticky flag: trace record dropped

Behaviour:
- Reset values: init_busy=1, addr_err=0, trace_valid=0, trace_count=0, trace_overflow=0; trace_pc/addr/data/byteen=0; m_data_rdata=0.
- Reset takes effect immediately (asynchronous). It forces state INIT, init counter=0, FIFO pointers=0, sticky flags=0. RAM contents are not reset directly; the sweep clears them.
- Reset asserted mid-operation, including mid-INIT: same as above. The sweep restarts from word 0 after release.
- State INIT:
  - Writes 0 to word init_cnt each cycle, then increments init_cnt.
  - After the cycle that writes word DEPTH_WORDS-1, moves to RUN.
  - init_busy=1 for exactly DEPTH_WORDS cycles after reset release.
  - CPU writes are ignored, no trace pushes, m_data_rdata=0.
- State RUN: init_busy=0; no exit except reset.
- Address decode:
  - Word index = m_data_addr[AW+1:2].
  - In range iff m_data_addr[31:AW+2]==0.
  - m_data_addr[1:0] is ignored for indexing.
- Read:
  - m_data_rdata = RAM[index] when in RUN and in range, else 0.
  - Purely combinational; no latency.
  - A same-cycle write is not visible until after the clock edge, so the read returns the old word.
- Write, at posedge:
  - Accepted when RUN, m_data_byteen!=0 and in range.
  - Byte lane i (bits 8i+7:8i) is updated from m_data_wdata lane i iff byteen[i]=1.
  - Other lanes keep their old values.
- Out-of-range store (RUN, byteen!=0, not in range): dropped, addr_err set, no trace push, RAM unchanged. Out-of-range reads are silent.
- Trace push:
  - Every accepted write pushes {m_inst_addr, {m_data_addr[31:2],2'b00}, merged word, byteen}.
  - Merged word = new lanes OR'd with unchanged old lanes.
- Trace pop: occurs when trace_valid && trace_ready at posedge.
- Head outputs:
  - Show the oldest entry while trace_valid=1.
  - Held stable while valid && !ready.
  - Forced to 0 when empty.
- FIFO boundary cases:
  - Push into an empty FIFO: trace_valid rises next cycle; no same-cycle bypass.
  - Push while full without a pop: record dropped, trace_overflow set, count stays TRACE_DEPTH.
  - Push while full with a pop in the same cycle: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle otherwise: count unchanged.
  - Pointers are TW bits and wrap modulo TRACE_DEPTH.
  - trace_count = TRACE_DEPTH (full) is only reachable via the extra count bit.
- Sticky flags clear only on reset.

Test Plan:
1. Assert reset for 3 cycles, release -> init_busy=1 for exactly 1024 cycles then 0; afterwards m_data_addr=0x0000_0010 gives m_data_rdata=0x0000_0000; trace_count=0.
2. RUN, addr 0x40, wdata 0xDEADBEEF, byteen 4'b1111, pc 0x3010 -> next cycle rdata@0x40 = 0xDEADBEEF; trace_valid=1 with head {0x3010, 0x40, 0xDEADBEEF, 4'hF}.
3. Partial writes on top of scenario 2:
   - Addr 0x43, wdata 0x1100_0000, byteen 4'b1000 -> word = 0x11ADBEEF.
   - Then addr 0x40, wdata 0x0000_2222, byteen 4'b0011 -> word = 0x11AD2222; trace_data of that entry = 0x11AD2222.
4. FIFO full/empty:
   - trace_ready=0, 9 accepted stores (pc 0x3000..0x3020 step 4) -> trace_count=8, trace_overflow=1.
   - Then trace_ready=1 -> pops pcs 0x3000..0x301C in order; trace_valid=0 after the 8th pop; count=0.
5. Out-of-range stores:
   - Store to 0x0000_1000 -> addr_err=1, no trace push.
   - Store to 0x8000_0040 -> addr_err stays 1; rdata@0x40 unchanged.
   - Read of 0x0000_1000 returns 0.
6. Simultaneous events:
   - FIFO full with trace_ready=1 and a store in the same cycle -> count stays 8, overflow stays 0, new record becomes the tail.
   - Reset asserted at INIT cycle 500 for 2 cycles -> init_busy stays 1, flags cleared, full 1024-cycle sweep after release.
